// File: rtl/pipeline_front_ctrl.sv
// Front-end sequencer for the 16-bit, 16-register 5-stage core.
// Holds the PC, the IF/ID register and the ID/EX register. It feeds the hazard unit its
// operands and obeys that unit's PCWrite/IFIDWrite/ST responses. It also applies EX-stage
// branch-redirect flushes and keeps saturating stall and flush counters.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   PCWrite, IFIDWrite  hazard-unit enables for the PC and IF/ID (0 = hold)
//   ST                  hazard-unit bubble request for ID/EX
//   redirect            EX branch taken; redirect_pc is the new PC
//   imem_addr           current PC to the async instruction memory
//   imem_rdata          instruction at imem_addr in the same cycle
//   IF_ID_RS/RT         raw source fields of the IF/ID instruction
//   IF_ID_valid         IF/ID holds a real instruction
//   ID_EX_*             registered decoded controls, fields, PC and valid bit
//   stall_count         bubbles inserted, saturating
//   flush_count         redirect events, saturating
module pipeline_front_ctrl #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000,
   parameter logic [3:0]  LOAD_OP   = 4'h8,
   parameter logic [3:0]  STORE_OP  = 4'h9,
   parameter logic [3:0]  BEQ_OP    = 4'hA
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        IFIDWrite,
   input  logic        ST,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   output logic [3:0]  IF_ID_RS,
   output logic [3:0]  IF_ID_RT,
   output logic        IF_ID_valid,
   output logic        ID_EX_valid,
   output logic        ID_EX_MemRead,
   output logic        ID_EX_MemWrite,
   output logic        ID_EX_RegWrite,
   output logic        ID_EX_Branch,
   output logic [3:0]  ID_EX_RD,
   output logic [3:0]  ID_EX_RS,
   output logic [3:0]  ID_EX_RT,
   output logic [3:0]  ID_EX_op,
   output logic [15:0] ID_EX_pc,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   logic [15:0] pc_q;
   logic [15:0] ifid_instr_q;
   logic [15:0] ifid_pc_q;
   logic        ifid_valid_q;

   logic        idex_valid_q;
   logic        idex_mem_read_q;
   logic        idex_mem_write_q;
   logic        idex_reg_write_q;
   logic        idex_branch_q;
   logic [3:0]  idex_rd_q;
   logic [3:0]  idex_rs_q;
   logic [3:0]  idex_rt_q;
   logic [3:0]  idex_op_q;
   logic [15:0] idex_pc_q;

   logic [15:0] stall_q;
   logic [15:0] flush_q;

   // Decode of the instruction currently in IF/ID
   logic [3:0] dec_op;
   logic       dec_mem_read;
   logic       dec_mem_write;
   logic       dec_reg_write;
   logic       dec_branch;

   always_comb begin
      dec_op        = ifid_instr_q[15:12];
      dec_mem_read  = (dec_op == LOAD_OP);
      dec_mem_write = (dec_op == STORE_OP);
      dec_branch    = (dec_op == BEQ_OP);
      // NOP shares the ALU opcode space, so exclude it explicitly
      dec_reg_write = ((dec_op <= 4'h7) && (ifid_instr_q != NOP_INSTR)) ||
                      (dec_op == LOAD_OP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q             <= RESET_PC;
         ifid_instr_q     <= NOP_INSTR;
         ifid_pc_q        <= 16'h0000;
         ifid_valid_q     <= 1'b0;
         idex_valid_q     <= 1'b0;
         idex_mem_read_q  <= 1'b0;
         idex_mem_write_q <= 1'b0;
         idex_reg_write_q <= 1'b0;
         idex_branch_q    <= 1'b0;
         idex_rd_q        <= 4'h0;
         idex_rs_q        <= 4'h0;
         idex_rt_q        <= 4'h0;
         idex_op_q        <= 4'h0;
         idex_pc_q        <= 16'h0000;
         stall_q          <= 16'h0000;
         flush_q          <= 16'h0000;
      end else begin
         if (redirect) begin
            pc_q <= redirect_pc;
         end else if (PCWrite) begin
            pc_q <= pc_q + 16'd1;
         end

         // IF/ID pc is left untouched on a flush; the slot is marked invalid
         if (redirect) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
         end else if (IFIDWrite) begin
            ifid_instr_q <= imem_rdata;
            ifid_pc_q    <= pc_q;
            ifid_valid_q <= 1'b1;
         end

         if (redirect || ST) begin
            idex_valid_q     <= 1'b0;
            idex_mem_read_q  <= 1'b0;
            idex_mem_write_q <= 1'b0;
            idex_reg_write_q <= 1'b0;
            idex_branch_q    <= 1'b0;
            idex_rd_q        <= 4'h0;
            idex_rs_q        <= 4'h0;
            idex_rt_q        <= 4'h0;
            idex_op_q        <= 4'h0;
            idex_pc_q        <= 16'h0000;
         end else begin
            idex_valid_q     <= ifid_valid_q;
            idex_mem_read_q  <= dec_mem_read;
            idex_mem_write_q <= dec_mem_write;
            idex_reg_write_q <= dec_reg_write;
            idex_branch_q    <= dec_branch;
            idex_rd_q        <= ifid_instr_q[11:8];
            idex_rs_q        <= ifid_instr_q[7:4];
            idex_rt_q        <= ifid_instr_q[3:0];
            idex_op_q        <= dec_op;
            idex_pc_q        <= ifid_pc_q;
         end

         // A stall overridden by a redirect is a flush, not a bubble
         if (ST && !redirect && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
         if (redirect && (flush_q != 16'hFFFF)) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

   assign imem_addr      = pc_q;
   assign IF_ID_RS       = ifid_instr_q[7:4];
   assign IF_ID_RT       = ifid_instr_q[3:0];
   assign IF_ID_valid    = ifid_valid_q;
   assign ID_EX_valid    = idex_valid_q;
   assign ID_EX_MemRead  = idex_mem_read_q;
   assign ID_EX_MemWrite = idex_mem_write_q;
   assign ID_EX_RegWrite = idex_reg_write_q;
   assign ID_EX_Branch   = idex_branch_q;
   assign ID_EX_RD       = idex_rd_q;
   assign ID_EX_RS       = idex_rs_q;
   assign ID_EX_RT       = idex_rt_q;
   assign ID_EX_op       = idex_op_q;
   assign ID_EX_pc       = idex_pc_q;
   assign stall_count    = stall_q;
   assign flush_count    = flush_q;

endmodule
